regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 15-entry Y86 register file between two writeback requesters. Port E carries valE/dstE; port M carries valM/dstM.
Each port has a one-entry holding buffer, and the block grants at most one write per cycle. Ordering is oldest-first, with a fixed E-before-M rule for same-cycle, same-register pairs so that valM wins (popq %rsp semantics).
Exports a pending-write mask that decode uses to stall reads of registers not yet written.

---
 rtl/y86_pkg.sv | 30 +++
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/wb_hold_buf.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Y86 register-file constants and the writeback request record shared by
// decode and the writeback arbiter.
package y86_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int NREG   = 15;

  localparam logic [ADDR_W-1:0] RNONE = 4'hF;
  localparam logic [ADDR_W-1:0] RSP   = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {PORT_E = 1'b0, PORT_M = 1'b1} wb_port_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester ports (E and M), register-file write port and status.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = y86_pkg::DATA_W,
  parameter int ADDR_W = y86_pkg::ADDR_W,
  parameter int NREG   = y86_pkg::NREG
);
  logic              e_valid, e_ready;
  logic [ADDR_W-1:0] e_dst;
  logic [DATA_W-1:0] e_data;
  logic              m_valid, m_ready;
  logic [ADDR_W-1:0] m_dst;
  logic [DATA_W-1:0] m_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   busy;
  logic              idle;

  modport master (
    output e_valid, e_dst, e_data, m_valid, m_dst, m_data,
    input  e_ready, m_ready, wr_en, wr_addr, wr_data, busy, idle
  );
  modport slave (
    input  e_valid, e_dst, e_data, m_valid, m_dst, m_data,
    output e_ready, m_ready, wr_en, wr_addr, wr_data, busy, idle
  );
endinterface

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready holding register; RNONE requests handshake but never load.
module wb_hold_buf
  import y86_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    ready,
  output logic    load,
  output logic    v,
  output wb_req_t q
);
  assign ready = !v || grant;
  assign load  = in_valid && ready && (in_req.dst != RNONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      q <= '0;
    end else if (load) begin
      v <= 1'b1;
      q <= in_req;
    end else if (grant) begin
      v <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between writeback ports E and M:
// oldest first, E before M on same-age same-register pairs, round-robin otherwise.
module regfile_wb_arbiter
  import y86_pkg::*;
(
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);
  wb_req_t  e_q, m_q;
  logic     e_v, m_v, e_ld, m_ld, g_e, g_m, rr_pick;
  logic     e_older, m_older;
  wb_port_t rr_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  wb_hold_buf u_e (
    .clk(clk), .rst_n(rst_n), .in_valid(bus.e_valid),
    .in_req('{dst: bus.e_dst, data: bus.e_data}), .grant(g_e),
    .ready(bus.e_ready), .load(e_ld), .v(e_v), .q(e_q)
  );
  wb_hold_buf u_m (
    .clk(clk), .rst_n(rst_n), .in_valid(bus.m_valid),
    .in_req('{dst: bus.m_dst, data: bus.m_data}), .grant(g_m),
    .ready(bus.m_ready), .load(m_ld), .v(m_v), .q(m_q)
  );

  always_comb begin
    g_e     = 1'b0;
    g_m     = 1'b0;
    rr_pick = 1'b0;
    if (e_v && !m_v)             g_e = 1'b1;
    else if (m_v && !e_v)        g_m = 1'b1;
    else if (e_v && m_v) begin
      if (e_older)               g_e = 1'b1;
      else if (m_older)          g_m = 1'b1;
      else if (e_q.dst == m_q.dst) g_e = 1'b1;  // valM must land last
      else begin
        rr_pick = 1'b1;
        if (rr_last == PORT_M)   g_e = 1'b1;
        else                     g_m = 1'b1;
      end
    end
  end

  // A buffer reloaded on its grant edge is younger than anything else resident.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_older <= 1'b0;
      m_older <= 1'b0;
      rr_last <= PORT_M;
    end else begin
      if (rr_pick) rr_last <= g_m ? PORT_M : PORT_E;
      if ((e_v && !g_e) && (m_v && !g_m)) begin
        e_older <= e_older;
        m_older <= m_older;
      end else if ((e_v && !g_e) && m_ld) begin
        e_older <= 1'b1;
        m_older <= 1'b0;
      end else if ((m_v && !g_m) && e_ld) begin
        e_older <= 1'b0;
        m_older <= 1'b1;
      end else if (e_ld && m_ld) begin
        e_older <= g_m;
        m_older <= g_e;
      end else begin
        e_older <= 1'b0;
        m_older <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (g_e) begin
      wr_en   <= 1'b1;
      wr_addr <= e_q.dst;
      wr_data <= e_q.data;
    end else if (g_m) begin
      wr_en   <= 1'b1;
      wr_addr <= m_q.dst;
      wr_data <= m_q.data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign bus.busy[r] = (e_v && e_q.dst == ADDR_W'(r)) ||
                         (m_v && m_q.dst == ADDR_W'(r)) ||
                         (wr_en && wr_addr == ADDR_W'(r));
  end

  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.idle    = !e_v && !m_v && !wr_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed writeback scenarios plus randomized traffic
// compared every cycle against an age-stamp model of the arbiter.
module tb_regfile_wb_arbiter;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each resident entry carries a load stamp; smaller stamp is older.
  bit        mev = 0, mmv = 0, mwen = 0, mrr_m = 1;
  bit [3:0]  med = 0, mmd = 0, maddr = 0;
  bit [63:0] medata = 0, mmdata = 0, mdata = 0;
  int        estamp = 0, mstamp = 0, cyc = 0;
  bit        e_xf = 0, m_xf = 0;

  function automatic void mgrant(output bit ge, output bit gm, output bit rr);
    ge = 0; gm = 0; rr = 0;
    if (mev && !mmv) ge = 1;
    else if (mmv && !mev) gm = 1;
    else if (mev && mmv) begin
      if (estamp < mstamp) ge = 1;
      else if (mstamp < estamp) gm = 1;
      else if (med == mmd) ge = 1;
      else begin rr = 1; if (mrr_m) ge = 1; else gm = 1; end
    end
  endfunction

  initial begin
    bit ge, gm, rr;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mev = 0; mmv = 0; mwen = 0; maddr = 0; mdata = 0; mrr_m = 1;
        e_xf = 0; m_xf = 0;
      end else begin
        mgrant(ge, gm, rr);
        e_xf = bus.e_valid && (!mev || ge);
        m_xf = bus.m_valid && (!mmv || gm);
        if (ge) begin mwen = 1; maddr = med; mdata = medata; end
        else if (gm) begin mwen = 1; maddr = mmd; mdata = mmdata; end
        else mwen = 0;
        if (rr) mrr_m = gm;
        if (ge) mev = 0;
        if (gm) mmv = 0;
        if (e_xf && bus.e_dst != RNONE) begin
          mev = 1; med = bus.e_dst; medata = bus.e_data; estamp = 2 * cyc + (ge ? 1 : 0);
        end
        if (m_xf && bus.m_dst != RNONE) begin
          mmv = 1; mmd = bus.m_dst; mmdata = bus.m_data; mstamp = 2 * cyc + (gm ? 1 : 0);
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    bit ge, gm, rr;
    logic [NREG-1:0] eb;
    forever begin
      @(negedge clk);
      mgrant(ge, gm, rr);
      eb = '0;
      for (int r = 0; r < NREG; r++)
        eb[r] = (mev && med == r) || (mmv && mmd == r) || (mwen && maddr == r);
      chk("wr_en",   64'(bus.wr_en),   64'(mwen));
      chk("wr_addr", 64'(bus.wr_addr), 64'(maddr));
      chk("wr_data", bus.wr_data,      mdata);
      chk("busy",    64'(bus.busy),    64'(eb));
      chk("idle",    64'(bus.idle),    64'(!mev && !mmv && !mwen));
      chk("e_ready", 64'(bus.e_ready), 64'(!mev || ge));
      chk("m_ready", 64'(bus.m_ready), 64'(!mmv || gm));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit ev, input logic [3:0] ed, input logic [63:0] edat,
                       input bit mv, input logic [3:0] md, input logic [63:0] mdat);
    bus.e_valid = ev; bus.e_dst = ed; bus.e_data = edat;
    bus.m_valid = mv; bus.m_dst = md; bus.m_data = mdat;
  endtask

  function automatic logic [3:0] pick_dst();
    int r = $urandom % 8;
    if (r < 6) return 4'($urandom % 4);
    if (r == 6) return 4'($urandom % 15);
    return RNONE;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #12 rst_n = 1'b1;
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    tick();

    // E only
    drive(1, 4'd3, 64'hAA, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0);
    chk("t1_wen0", 64'(bus.wr_en), 64'd0);
    chk("t1_busy_buf", 64'(bus.busy[3]), 64'd1);
    tick();
    chk("t1_wen", 64'(bus.wr_en), 64'd1);
    chk("t1_addr", 64'(bus.wr_addr), 64'd3);
    chk("t1_data", bus.wr_data, 64'hAA);
    chk("t1_busy_wr", 64'(bus.busy[3]), 64'd1);
    tick();
    chk("t1_idle", 64'(bus.idle), 64'd1);
    chk("t1_busy_clr", 64'(bus.busy), 64'd0);

    // same-cycle same-register pair: valM lands last
    drive(1, 4'd4, 64'h100, 1, 4'd4, 64'h200); tick(); drive(0, 0, 0, 0, 0, 0);
    chk("t2_m_wait", 64'(bus.m_ready), 64'd0);
    tick();
    chk("t2_first", bus.wr_data, 64'h100);
    chk("t2_addr1", 64'(bus.wr_addr), 64'd4);
    tick();
    chk("t2_second", bus.wr_data, 64'h200);
    chk("t2_wen2", 64'(bus.wr_en), 64'd1);
    tick();
    chk("t2_idle", 64'(bus.idle), 64'd1);

    // round-robin alternation across two distinct-register pairs
    drive(1, 4'd1, 64'h11, 1, 4'd2, 64'h22); tick(); drive(0, 0, 0, 0, 0, 0);
    tick(); chk("t3_p1a", 64'(bus.wr_addr), 64'd1);
    tick(); chk("t3_p1b", 64'(bus.wr_addr), 64'd2);
    tick();
    drive(1, 4'd1, 64'h11, 1, 4'd2, 64'h22); tick(); drive(0, 0, 0, 0, 0, 0);
    tick(); chk("t3_p2a", 64'(bus.wr_addr), 64'd2);
    tick(); chk("t3_p2b", 64'(bus.wr_addr), 64'd1);
    tick();

    // RNONE is accepted and discarded
    drive(0, 0, 0, 1, RNONE, 64'h55);
    chk("t4_ready", 64'(bus.m_ready), 64'd1);
    tick(); drive(0, 0, 0, 0, 0, 0);
    chk("t4_wen", 64'(bus.wr_en), 64'd0);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_idle", 64'(bus.idle), 64'd1);
    tick();
    chk("t4_wen2", 64'(bus.wr_en), 64'd0);

    // reset mid-burst with both buffers full and a write in flight
    drive(1, 4'd1, 64'h11, 1, 4'd2, 64'h22); tick();
    drive(1, 4'd3, 64'h33, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0);
    chk("t6_wen", 64'(bus.wr_en), 64'd1);
    chk("t6_full", 64'(bus.busy), 64'h000E);
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_wen", 64'(bus.wr_en), 64'd0);
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    chk("t6_rst_idle", 64'(bus.idle), 64'd1);
    #1 rst_n = 1'b1;
    #1 chk("t6_erdy", 64'(bus.e_ready), 64'd1);
    chk("t6_mrdy", 64'(bus.m_ready), 64'd1);
    tick(); chk("t6_nowr", 64'(bus.wr_en), 64'd0);
    tick(); chk("t6_nowr2", 64'(bus.wr_en), 64'd0);

    // randomized traffic; requesters hold until their transfer completes
    for (int i = 0; i < 3000; i++) begin
      if (!bus.e_valid || e_xf) begin
        bus.e_valid = ($urandom % 10) < 6;
        bus.e_dst   = pick_dst();
        bus.e_data  = {$urandom, $urandom};
      end
      if (!bus.m_valid || m_xf) begin
        bus.m_valid = ($urandom % 10) < 6;
        bus.m_dst   = pick_dst();
        bus.m_data  = {$urandom, $urandom};
      end
      if (i % 600 == 300) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
